// File: rtl/fp8_line_ram_ctrl.sv
// fp8_line_ram_ctrl
//   Memory side of the FP8 line-buffer path. Each valid pixel word is written
//   into a circular one-line RAM. The word that was stored in the same column
//   one line earlier is returned, which gives the line unit its one-row-delayed
//   taps. The RAM is single-address and read-first.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   cfg_line_len  pixels per line, sampled on sof (0 or >LINE_MAX means LINE_MAX)
//   sof           start of frame, qualified by in_valid
//   in_valid      RAM_in_g carries a pixel this cycle
//   RAM_in_g      packed FP8 write word {lane(LANES-1) .. lane0}
//   RAM_out_g     packed FP8 word from the same column of the previous line
//   out_valid     RAM_out_g valid, 1 cycle after in_valid
//   out_primed    a full line has been stored since sof/reset (aligned with RAM_out_g)
//   parity_err    lane parity mismatch on a primed read word
//
// Configuration macro
//   LB_PARITY_EN  store one even-parity bit per lane and check it on read.
//                 When undefined, parity_err is tied to 0.
module fp8_line_ram_ctrl #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned LINE_MAX = 640,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W:0]      cfg_line_len,
  input  logic                 sof,
  input  logic                 in_valid,
  input  logic [8*LANES-1:0]   RAM_in_g,
  output logic [8*LANES-1:0]   RAM_out_g,
  output logic                 out_valid,
  output logic                 out_primed,
  output logic                 parity_err
);

  localparam int unsigned DW = 8 * LANES;
`ifdef LB_PARITY_EN
  localparam int unsigned MW = DW + LANES;
`else
  localparam int unsigned MW = DW;
`endif
  localparam logic [ADDR_W:0] LineMaxW = (ADDR_W + 1)'(LINE_MAX);
  localparam logic [ADDR_W:0] OneW     = (ADDR_W + 1)'(1);

  // Line RAM, never reset.
  logic [MW-1:0] mem [LINE_MAX];

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   line_len_q;
  logic              primed_q;
  logic              out_valid_q;
  logic              out_primed_q;
  logic [MW-1:0]     rd_q;

  logic [ADDR_W:0]   cfg_clamped;
  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W-1:0] addr;
  logic              primed_eff;
  logic              wrap;
  logic [MW-1:0]     wr_word;

  // A sof pixel sees the new line length, address 0 and a cleared primed flag
  // in the same cycle it is accepted.
  always_comb begin
    cfg_clamped = cfg_line_len;
    if (cfg_line_len == '0 || cfg_line_len > LineMaxW) begin
      cfg_clamped = LineMaxW;
    end
    len_eff    = sof ? cfg_clamped : line_len_q;
    addr       = sof ? '0 : ptr_q;
    primed_eff = sof ? 1'b0 : primed_q;
    wrap       = ({1'b0, addr} == (len_eff - OneW));
  end

`ifdef LB_PARITY_EN
  logic [LANES-1:0] wr_par;
  logic [LANES-1:0] rd_mismatch;

  always_comb begin
    wr_par      = '0;
    rd_mismatch = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      wr_par[k]      = ^RAM_in_g[8*k +: 8];
      rd_mismatch[k] = (^rd_q[8*k +: 8]) ^ rd_q[DW + k];
    end
  end

  assign wr_word    = {wr_par, RAM_in_g};
  // Only primed words carry meaningful parity; masked rows never flag.
  assign parity_err = out_valid_q & out_primed_q & (|rd_mismatch);
`else
  assign wr_word    = RAM_in_g;
  assign parity_err = 1'b0;
`endif

  // Read-first RAM port. A pixel arriving during reset is dropped.
  always_ff @(posedge clk) begin
    if (in_valid && !reset) begin
      rd_q      <= mem[addr];
      mem[addr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      line_len_q   <= LineMaxW;
      primed_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_primed_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        line_len_q   <= len_eff;
        out_primed_q <= primed_eff;
        if (wrap) begin
          ptr_q    <= '0;
          primed_q <= 1'b1;
        end else begin
          ptr_q    <= addr + 1'b1;
          primed_q <= primed_eff;
        end
      end
    end
  end

  // Unprimed rows read as FP8 zero; the mask flag is held between pixels so
  // the output word also holds.
  assign RAM_out_g  = out_primed_q ? rd_q[DW-1:0] : '0;
  assign out_valid  = out_valid_q;
  assign out_primed = out_primed_q;

endmodule

// File: tb/tb_fp8_line_ram_ctrl.sv
module tb_fp8_line_ram_ctrl;

  localparam int unsigned LANES    = 2;
  localparam int unsigned LINE_MAX = 8;
  localparam int unsigned ADDR_W   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W:0]   cfg_line_len;
  logic              sof;
  logic              in_valid;
  logic [15:0]       RAM_in_g;
  logic [15:0]       RAM_out_g;
  logic              out_valid;
  logic              out_primed;
  logic              parity_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] last_out;

  fp8_line_ram_ctrl #(
    .LANES    (LANES),
    .LINE_MAX (LINE_MAX),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_line_len (cfg_line_len),
    .sof          (sof),
    .in_valid     (in_valid),
    .RAM_in_g     (RAM_in_g),
    .RAM_out_g    (RAM_out_g),
    .out_valid    (out_valid),
    .out_primed   (out_primed),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One pixel: drive on the falling edge, check the registered result 1 unit
  // after the next rising edge.
  task automatic px(input string tag, input logic [15:0] d, input logic s,
                    input logic [15:0] exp_out, input logic exp_primed, input logic exp_perr);
    @(negedge clk);
    in_valid = 1'b1;
    sof      = s;
    RAM_in_g = d;
    @(posedge clk);
    #1;
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".data"}, 32'(RAM_out_g), 32'(exp_out));
    check_eq({tag, ".primed"}, 32'(out_primed), 32'(exp_primed));
    check_eq({tag, ".perr"}, 32'(parity_err), 32'(exp_perr));
    last_out = exp_out;
  endtask

  // Gap cycle: no valid, output word holds.
  task automatic idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    sof      = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, ".gap_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".gap_hold"}, 32'(RAM_out_g), 32'(last_out));
  endtask

  function automatic logic [15:0] rep(input int v);
    return {v[7:0], v[7:0]};
  endfunction

  initial begin
    reset        = 1'b1;
    cfg_line_len = 4'd4;
    sof          = 1'b0;
    in_valid     = 1'b0;
    RAM_in_g     = '0;
    last_out     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.valid", 32'(out_valid), 32'd0);
    check_eq("rst.data", 32'(RAM_out_g), 32'd0);
    check_eq("rst.primed", 32'(out_primed), 32'd0);
    check_eq("rst.perr", 32'(parity_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Prime a 4-pixel line.
    px("prime0", 16'h0101, 1'b1, 16'h0000, 1'b0, 1'b0);
    px("prime1", 16'h0202, 1'b0, 16'h0000, 1'b0, 1'b0);
    px("prime2", 16'h0303, 1'b0, 16'h0000, 1'b0, 1'b0);
    px("prime3", 16'h0404, 1'b0, 16'h0000, 1'b0, 1'b0);
    px("prime4", 16'h0505, 1'b0, 16'h0101, 1'b1, 1'b0);

    // Steady state with gaps: output equals input 4 pixels earlier.
    for (int i = 6; i <= 17; i++) begin
      idle("steady");
      px("steady", rep(i), 1'b0, rep(i - 4), 1'b1, 1'b0);
    end

    // Mid-line sof (ptr is at column 1): mask for one new line.
    px("msof0", 16'h2020, 1'b1, 16'h0000, 1'b0, 1'b0);
    px("msof1", 16'h2121, 1'b0, 16'h0000, 1'b0, 1'b0);
    px("msof2", 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0);
    px("msof3", 16'h2323, 1'b0, 16'h0000, 1'b0, 1'b0);
    px("msof4", 16'h2424, 1'b0, 16'h2020, 1'b1, 1'b0);
    px("msof5", 16'h2525, 1'b0, 16'h2121, 1'b1, 1'b0);

    // cfg_line_len = 0 clamps to LINE_MAX.
    cfg_line_len = 4'd0;
    for (int k = 0; k < 8; k++) begin
      px("clamp0", rep(8'h30 + k), (k == 0), 16'h0000, 1'b0, 1'b0);
    end
    px("clamp0_d", 16'h3838, 1'b0, 16'h3030, 1'b1, 1'b0);

    // cfg_line_len = 9 (> LINE_MAX) clamps to LINE_MAX.
    cfg_line_len = 4'd9;
    for (int k = 0; k < 8; k++) begin
      px("clamp9", rep(8'h40 + k), (k == 0), 16'h0000, 1'b0, 1'b0);
    end
    px("clamp9_d", 16'h4848, 1'b0, 16'h4040, 1'b1, 1'b0);

    // cfg_line_len = 1: every pixel wraps.
    cfg_line_len = 4'd1;
    px("len1_0", 16'h5050, 1'b1, 16'h0000, 1'b0, 1'b0);
    px("len1_1", 16'h5151, 1'b0, 16'h5050, 1'b1, 1'b0);
    cfg_line_len = 4'd4;  // ignored without sof
    px("len1_2", 16'h5252, 1'b0, 16'h5151, 1'b1, 1'b0);
    px("len1_3", 16'h5353, 1'b0, 16'h5252, 1'b1, 1'b0);

    // Reset during a valid pixel.
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    RAM_in_g = 16'h7777;
    @(posedge clk);
    #1;
    check_eq("rstmid.valid", 32'(out_valid), 32'd0);
    check_eq("rstmid.data", 32'(RAM_out_g), 32'd0);
    check_eq("rstmid.primed", 32'(out_primed), 32'd0);
    last_out = '0;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    idle("rstmid");
    px("post0", 16'h6060, 1'b1, 16'h0000, 1'b0, 1'b0);
    px("post1", 16'h6161, 1'b0, 16'h0000, 1'b0, 1'b0);
    px("post2", 16'h6262, 1'b0, 16'h0000, 1'b0, 1'b0);
    px("post3", 16'h6363, 1'b0, 16'h0000, 1'b0, 1'b0);
    px("post4", 16'h6464, 1'b0, 16'h6060, 1'b1, 1'b0);
    px("post5", 16'h6565, 1'b0, 16'h6161, 1'b1, 1'b0);

    // Column 2 holds 0x6262; corrupt a lane1 data bit when parity is built in.
    idle("par");
`ifdef LB_PARITY_EN
    dut.mem[2][15] = ~dut.mem[2][15];
    px("par_bad", 16'h6666, 1'b0, 16'he262, 1'b1, 1'b1);
`else
    px("par_off", 16'h6666, 1'b0, 16'h6262, 1'b1, 1'b0);
`endif
    px("par_next", 16'h6767, 1'b0, 16'h6363, 1'b1, 1'b0);
    idle("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
